// File: rtl/draw_pkg.sv
// Shared types for the frame draw blocks: sequencer state encoding
// and the default erase colour.
package draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_GO,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_GO,
    S_DRAW_WAIT
  } draw_state_t;

  localparam int BG_COLOR_DEF = 0;

endpackage

// File: rtl/draw_watchdog.sv
// Done-wait watchdog: counts wait cycles after a clear and flags the
// (2^TO_W-1)th one so the sequencer can skip a silent drawer.
module draw_watchdog #(
  parameter int TO_W = 12
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  // cnt holds the number of the current wait cycle (1-based)
  assign expire = en && (cnt == '1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= TO_W'(1);
    end else if (en && !expire) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: erase pass, update pulse, draw pass over the enabled
// drawer channels, muxing only the active channel onto the VGA port.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int BG_COLOR = BG_COLOR_DEF,
  parameter int TO_W     = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_tick,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_go,
  input  logic [NUM_CH-1:0]       ch_done,
  input  logic [NUM_CH-1:0]       ch_plot,
  input  logic [NUM_CH*X_W-1:0]   ch_x,
  input  logic [NUM_CH*Y_W-1:0]   ch_y,
  input  logic [NUM_CH*COLOR_W-1:0] ch_color,
  output logic                    erase,
  output logic                    update_en,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COLOR_W-1:0]      vga_color,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout,
  input  logic                    flag_clr
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  draw_state_t       state;
  draw_state_t       nstate;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nidx;
  logic [NUM_CH-1:0] en_q;
  logic [IW:0]       hit;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_exp;
  logic              to_set;
  logic              done_sel;
  logic              in_erase;
  logic              in_pass;
  logic              px_take;

  // {found, index} of the lowest set bit of m at or above lo
  function automatic logic [IW:0] first_from(
    input logic [NUM_CH-1:0] m,
    input int                lo
  );
    logic [IW:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m[k] && (k >= lo)) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

  assign wd_clr   = (state == S_ERASE_GO) || (state == S_DRAW_GO);
  assign wd_en    = (state == S_ERASE_WAIT) || (state == S_DRAW_WAIT);
  assign in_erase = (state == S_ERASE_GO) || (state == S_ERASE_WAIT);
  assign in_pass  = wd_clr || wd_en;
  assign done_sel = ch_done[idx];
  assign px_take  = in_pass && ch_plot[idx];

  draw_watchdog #(
    .TO_W(TO_W)
  ) u_wd (
    .clk   (clk),
    .resetn(resetn),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_exp)
  );

  always_comb begin
    nstate = state;
    nidx   = idx;
    to_set = 1'b0;
    hit    = '0;
    unique case (state)
      S_IDLE: begin
        if (frame_tick) begin
          hit    = first_from(ch_en, 0);
          nstate = hit[IW] ? S_ERASE_GO : S_UPDATE;
          nidx   = hit[IW] ? hit[IW-1:0] : '0;
        end
      end
      S_ERASE_GO: nstate = S_ERASE_WAIT;
      S_DRAW_GO:  nstate = S_DRAW_WAIT;
      S_ERASE_WAIT, S_DRAW_WAIT: begin
        if (done_sel || wd_exp) begin
          to_set = !done_sel;
          hit    = first_from(en_q, int'(idx) + 1);
          if (hit[IW]) begin
            nstate = (state == S_ERASE_WAIT) ? S_ERASE_GO : S_DRAW_GO;
            nidx   = hit[IW-1:0];
          end else begin
            nstate = (state == S_ERASE_WAIT) ? S_UPDATE : S_IDLE;
          end
        end
      end
      S_UPDATE: begin
        hit    = first_from(en_q, 0);
        nstate = hit[IW] ? S_DRAW_GO : S_IDLE;
        if (hit[IW]) nidx = hit[IW-1:0];
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      en_q      <= '0;
      ch_go     <= '0;
      erase     <= 1'b0;
      update_en <= 1'b0;
      busy      <= 1'b0;
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      if (state == S_IDLE && frame_tick) en_q <= ch_en;
      ch_go <= ((nstate == S_ERASE_GO) || (nstate == S_DRAW_GO))
             ? (NUM_CH'(1) << nidx) : '0;
      erase     <= (nstate == S_ERASE_GO) || (nstate == S_ERASE_WAIT);
      update_en <= (nstate == S_UPDATE);
      busy      <= (nstate != S_IDLE);
      vga_plot  <= px_take;
      if (px_take) begin
        vga_x     <= ch_x[idx*X_W +: X_W];
        vga_y     <= ch_y[idx*Y_W +: Y_W];
        vga_color <= in_erase ? COLOR_W'(BG_COLOR)
                              : ch_color[idx*COLOR_W +: COLOR_W];
      end
      // a set event in the same cycle beats flag_clr
      if (frame_tick && state != S_IDLE) overrun <= 1'b1;
      else if (flag_clr)                 overrun <= 1'b0;
      if (to_set)        timeout <= 1'b1;
      else if (flag_clr) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: per-frame expected timelines built from the
// channel schedule, random drawer traffic and noise, directed corner frames.
module tb_draw_sequencer;

  localparam int N  = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int TW = 4;
  localparam int L  = 256;

  logic          clk = 1'b0;
  logic          resetn;
  logic          frame_tick;
  logic          flag_clr;
  logic [N-1:0]  ch_en;
  logic [N-1:0]  ch_go;
  logic [N-1:0]  ch_done;
  logic [N-1:0]  ch_plot;
  logic [N*XW-1:0] ch_x;
  logic [N*YW-1:0] ch_y;
  logic [N*CW-1:0] ch_color;
  logic          erase;
  logic          update_en;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_color;
  logic          vga_plot;
  logic          busy;
  logic          overrun;
  logic          timeout;

  always #5 clk = ~clk;

  draw_sequencer #(
    .NUM_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
    .BG_COLOR(0), .TO_W(TW)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .ch_en(ch_en), .ch_go(ch_go), .ch_done(ch_done),
    .ch_plot(ch_plot), .ch_x(ch_x), .ch_y(ch_y),
    .ch_color(ch_color), .erase(erase), .update_en(update_en),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_plot(vga_plot), .busy(busy), .overrun(overrun),
    .timeout(timeout), .flag_clr(flag_clr)
  );

  int checks = 0;
  int failures = 0;

  // timeline of one frame, index = cycles after the tick
  logic [N-1:0]    e_go[L];
  bit              e_er[L];
  bit              e_up[L];
  bit              e_busy[L];
  bit              e_to[L];
  int              act[L];
  logic [N-1:0]    s_plot[L];
  logic [N-1:0]    s_done[L];
  logic [N*XW-1:0] s_x[L];
  logic [N*YW-1:0] s_y[L];
  logic [N*CW-1:0] s_c[L];

  int  plen[N];
  int  hang_ch;
  bit  ov_en;
  bit  ov_clr;
  int  rst_at;

  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [CW-1:0] m_c;
  bit            m_plot;
  bit            m_to;
  bit            m_ov;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input logic [N-1:0] go, input bit er,
                            input bit up, input bit bz);
    chk("ch_go", ch_go, go);
    chk("erase", erase, er);
    chk("update_en", update_en, up);
    chk("busy", busy, bz);
    chk("vga_plot", vga_plot, m_plot);
    chk("vga_x", vga_x, m_x);
    chk("vga_y", vga_y, m_y);
    chk("vga_color", vga_color, m_c);
    chk("timeout", timeout, m_to);
    chk("overrun", overrun, m_ov);
  endtask

  task automatic set_defaults();
    for (int k = 0; k < N; k++) plen[k] = $urandom_range(0, 4);
    hang_ch = -1;
    ov_en   = 1'b0;
    ov_clr  = 1'b0;
    rst_at  = -1;
  endtask

  task automatic run_frame(input logic [N-1:0] en);
    int g;
    int w;
    int e;
    int last_go;
    int ov_tick;
    int a;
    logic [N*XW-1:0] tx;
    logic [N*YW-1:0] ty;
    logic [N*CW-1:0] tc;
    for (int i = 0; i < L; i++) begin
      e_go[i]   = '0;
      e_er[i]   = 1'b0;
      e_up[i]   = 1'b0;
      e_busy[i] = 1'b0;
      e_to[i]   = 1'b0;
      act[i]    = -1;
      s_plot[i] = N'($urandom);
      s_done[i] = N'($urandom);
      s_x[i]    = (N*XW)'($urandom);
      s_y[i]    = (N*YW)'($urandom);
      s_c[i]    = (N*CW)'($urandom);
    end
    g = 1;
    last_go = 1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N; k++) begin
        if (en[k]) begin
          w = (k == hang_ch) ? (2**TW - 1) : plen[k] + 1;
          e_go[g] = N'(1 << k);
          for (int c = g; c <= g + w; c++) begin
            act[c]  = k;
            e_er[c] = (pass == 0);
          end
          for (int c = g + 1; c <= g + w; c++) begin
            s_done[c][k] = 1'b0;
            if (c <= g + plen[k]) s_plot[c][k] = 1'b1;
          end
          if (k == hang_ch) e_to[g + w + 1] = 1'b1;
          else s_done[g + w][k] = 1'b1;
          last_go = g;
          g = g + w + 1;
        end
      end
      if (pass == 0) begin
        e_up[g] = 1'b1;
        g++;
      end
    end
    e = g;
    for (int c = 1; c < e; c++) e_busy[c] = 1'b1;
    ov_tick = ov_en ? last_go + 1 : -1;
    ch_en = en;
    for (int c = 0; c <= e + 1; c++) begin
      frame_tick = (c == 0) || (c == ov_tick);
      flag_clr   = ov_clr && (c == ov_tick);
      resetn     = (c != rst_at);
      ch_plot    = s_plot[c];
      ch_done    = s_done[c];
      ch_x       = s_x[c];
      ch_y       = s_y[c];
      ch_color   = s_c[c];
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        m_plot = 1'b0;
        m_x = '0;
        m_y = '0;
        m_c = '0;
        m_to = 1'b0;
        m_ov = 1'b0;
        check_outs('0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        frame_tick = 1'b0;
        return;
      end
      if (flag_clr) begin
        m_to = 1'b0;
        m_ov = 1'b0;
      end
      if (c == ov_tick) m_ov = 1'b1;
      if (e_to[c + 1]) m_to = 1'b1;
      m_plot = 1'b0;
      a = act[c];
      if (a >= 0) begin
        if (s_plot[c][a]) begin
          tx = s_x[c];
          ty = s_y[c];
          tc = s_c[c];
          m_plot = 1'b1;
          m_x = tx[a*XW +: XW];
          m_y = ty[a*YW +: YW];
          m_c = e_er[c] ? CW'(0) : tc[a*CW +: CW];
        end
      end
      check_outs(e_go[c + 1], e_er[c + 1], e_up[c + 1], e_busy[c + 1]);
    end
    frame_tick = 1'b0;
    flag_clr   = 1'b0;
    ch_plot    = '0;
    ch_done    = '0;
  endtask

  initial begin
    resetn = 1'b0;
    frame_tick = 1'b0;
    flag_clr = 1'b0;
    ch_en = '0;
    ch_done = '0;
    ch_plot = '0;
    ch_x = '0;
    ch_y = '0;
    ch_color = '0;
    m_x = '0;
    m_y = '0;
    m_c = '0;
    m_plot = 1'b0;
    m_to = 1'b0;
    m_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs('0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // full frame, four pixels per drawer
    set_defaults();
    for (int k = 0; k < N; k++) plen[k] = 4;
    run_frame(3'b111);

    // channel 1 disabled, its traffic is noise
    set_defaults();
    run_frame(3'b101);

    // nothing enabled: tick, update, idle
    set_defaults();
    run_frame(3'b000);

    // channel 1 never answers
    set_defaults();
    plen[1] = 2;
    hang_ch = 1;
    run_frame(3'b111);

    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    m_to = 1'b0;
    m_ov = 1'b0;
    m_plot = 1'b0;
    chk("timeout_clr", timeout, m_to);
    chk("overrun_clr", overrun, m_ov);

    // second tick while drawing, with a simultaneous clear
    set_defaults();
    ov_en = 1'b1;
    ov_clr = 1'b1;
    run_frame(3'b111);

    // reset during channel 1 erase wait
    set_defaults();
    plen[0] = 0;
    plen[1] = 3;
    rst_at = 4;
    run_frame(3'b111);

    set_defaults();
    run_frame(3'b111);

    for (int f = 0; f < 8; f++) begin
      set_defaults();
      if ($urandom_range(0, 3) == 0) hang_ch = $urandom_range(0, N - 1);
      ov_en  = 1'(($urandom_range(0, 2)) == 0);
      ov_clr = 1'($urandom_range(0, 1));
      run_frame(N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
